// File: rtl/ecg_delta_decoder_if.sv
// Token-in / sample-out stream bundle of the ECG delta decoder.
// The master side feeds tokens and takes samples; the slave side is the decoder.
interface ecg_delta_decoder_if #(
    parameter int W = 16
) ();
    logic         tok_valid;
    logic         tok_ready;
    logic [11:0]  tok_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         frame_last;

    modport master (
        output tok_valid, tok_data, out_ready,
        input  tok_ready, out_valid, out_data, frame_last
    );

    modport slave (
        input  tok_valid, tok_data, out_ready,
        output tok_ready, out_valid, out_data, frame_last
    );
endinterface

// File: rtl/ecg_delta_decoder.sv
// Rebuilds signed ECG samples from zero-run and Golomb-Rice (k=3/4/5) delta tokens,
// accumulating onto a seeded base sample, one frame of FRAME_LEN samples per seed.
module ecg_delta_decoder #(
    parameter int FRAME_LEN = 8,
    parameter int W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_valid,
    input  logic [W-1:0]        seed,
    ecg_delta_decoder_if.slave  bus,
    output logic                err,
    output logic                busy
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   prev_r;
    logic [CW-1:0]  cnt_r;
    logic [5:0]     rem_r;
    logic           out_valid_r;
    logic [W-1:0]   out_data_r;
    logic           frame_last_r;
    logic           err_r;

    logic           tok_ready_s;
    logic           busy_s;
    logic           slot_free_s;
    logic           tok_fire_s;
    logic           is_run_s;
    logic [5:0]     run_len_s;
    logic           grc_load_s;
    logic           run_start_s;
    logic           run_load_s;
    logic           load_s;
    logic           last_s;
    logic           seed_load_s;
    logic [W-1:0]   sample_s;

    // Delta = (q <<< k) + r with q and r sign-extended; bits above k are ignored.
    function automatic logic [W-1:0] grc_delta(input logic [11:0] tok);
        logic [W-1:0] q_ext;
        logic [W-1:0] d;
        q_ext = {{(W-4){tok[9]}}, tok[9:6]};
        case (tok[11:10])
            2'b01:   d = (q_ext << 3'd3) + {{(W-4){tok[3]}}, tok[3:0]};
            2'b10:   d = (q_ext << 3'd4) + {{(W-5){tok[4]}}, tok[4:0]};
            2'b11:   d = (q_ext << 3'd5) + {{(W-6){tok[5]}}, tok[5:0]};
            default: d = {W{1'b0}};
        endcase
        return d;
    endfunction

    assign slot_free_s = !out_valid_r || bus.out_ready;
    assign tok_fire_s  = bus.tok_valid && tok_ready_s;
    assign is_run_s    = (bus.tok_data[11:10] == 2'b00);
    assign run_len_s   = bus.tok_data[5:0];
    assign grc_load_s  = tok_fire_s && !is_run_s;
    assign run_start_s = tok_fire_s && is_run_s && (run_len_s != 6'd0);
    assign run_load_s  = (state_r == ST_RUN) && slot_free_s;
    assign load_s      = grc_load_s || run_load_s;
    assign last_s      = load_s && (cnt_r == CNT_LAST);
    assign seed_load_s = (state_r == ST_IDLE) && seed_valid;
    assign sample_s    = grc_load_s ? (prev_r + grc_delta(bus.tok_data)) : prev_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the frame's last load wins over any pending run.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (seed_valid) state_s = ST_ACTIVE;
                else            state_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (last_s)           state_s = ST_IDLE;
                else if (run_start_s) state_s = ST_RUN;
                else                  state_s = ST_ACTIVE;
            end
            ST_RUN: begin
                if (last_s)                             state_s = ST_IDLE;
                else if (run_load_s && rem_r == 6'd1)   state_s = ST_ACTIVE;
                else                                    state_s = ST_RUN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State-decoded outputs; tok_ready never looks at tok_valid.
    always_comb begin
        tok_ready_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tok_ready_s = 1'b0;
                busy_s      = 1'b0;
            end
            ST_ACTIVE: begin
                tok_ready_s = slot_free_s;
                busy_s      = 1'b1;
            end
            ST_RUN: begin
                tok_ready_s = 1'b0;
                busy_s      = 1'b1;
            end
            default: begin
                tok_ready_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Reconstruction state: base sample, frame position and remaining run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            rem_r  <= 6'd0;
            err_r  <= 1'b0;
        end else begin
            if (seed_load_s)     prev_r <= seed;
            else if (grc_load_s) prev_r <= sample_s;
            else                 prev_r <= prev_r;

            if (seed_load_s) cnt_r <= {CW{1'b0}};
            else if (load_s) cnt_r <= last_s ? {CW{1'b0}} : (cnt_r + CNT_ONE);
            else             cnt_r <= cnt_r;

            if (run_start_s)     rem_r <= run_len_s;
            else if (last_s)     rem_r <= 6'd0;
            else if (run_load_s) rem_r <= rem_r - 6'd1;
            else                 rem_r <= rem_r;

            // A run still owing samples when the frame closes means the stream overran.
            if (run_load_s && last_s && (rem_r > 6'd1)) err_r <= 1'b1;
            else                                         err_r <= err_r;
        end
    end

    // Output register; holds steady under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {W{1'b0}};
            frame_last_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= sample_s;
            frame_last_r <= last_s;
        end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= out_data_r;
            frame_last_r <= frame_last_r;
        end else begin
            out_valid_r  <= out_valid_r;
            out_data_r   <= out_data_r;
            frame_last_r <= frame_last_r;
        end
    end

    assign bus.tok_ready  = tok_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.frame_last = frame_last_r;
    assign err            = err_r;
    assign busy           = busy_s;

endmodule
